// File: rtl/eater_pkg.sv
// Shared constants and loader state type for the eater RAM subsystem.
package eater_pkg;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned RAM_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } ld_state_t;

endpackage

// File: rtl/prog_loader.sv
// Streams a program into the 16x8 RAM from address 0, then optionally reads it
// back and compares checksums; holds the CPU off the bus while active.
module prog_loader #(
  parameter int unsigned ADDR_W = eater_pkg::ADDR_W,
  parameter int unsigned DATA_W = eater_pkg::DATA_W,
  parameter bit          VERIFY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              ri,
  output logic              ro,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] csum
);

  import eater_pkg::*;

  localparam int unsigned     DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  ld_state_t         state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   rptr;
  logic [DATA_W-1:0] rsum;
  logic [DATA_W-1:0] csum_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              ri_q;
  logic              xfer;
  logic              reading;

  assign xfer    = in_valid && (state == S_LOAD);
  assign reading = (state == S_VERIFY) && (rptr != count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      wptr   <= '0;
      count  <= '0;
      rptr   <= '0;
      rsum   <= '0;
      csum_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      ri_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          ri_q <= 1'b0;
          if (start) begin
            state  <= S_LOAD;
            wptr   <= '0;
            count  <= '0;
            rptr   <= '0;
            rsum   <= '0;
            csum_q <= '0;
          end
        end
        S_LOAD: begin
          // Accepted bytes land in the write stage; RAM write happens next cycle.
          ri_q <= xfer;
          if (xfer) begin
            addr_q <= wptr;
            data_q <= in_data;
            wptr   <= wptr + PTR_ONE;
            count  <= count + CNT_ONE;
            csum_q <= csum_q + in_data;
            if (in_last || (count == LAST_CNT))
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          ri_q  <= 1'b0;
          rptr  <= '0;
          rsum  <= '0;
          state <= VERIFY ? S_VERIFY : S_DONE;
        end
        S_VERIFY: begin
          ri_q <= 1'b0;
          if (reading) begin
            rsum <= rsum + mem_rdata;
            rptr <= rptr + CNT_ONE;
          end else begin
            state <= (rsum == csum_q) ? S_DONE : S_ERROR;
          end
        end
        default: begin
          ri_q  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy        = (state == S_LOAD) || (state == S_DRAIN) || (state == S_VERIFY);
    cpu_hold    = busy;
    in_ready    = (state == S_LOAD);
    done        = (state == S_DONE);
    error       = (state == S_ERROR);
    ri          = ri_q;
    ro          = reading;
    csum        = csum_q;
    mem_wdata   = ri_q ? data_q : '0;
    mem_address = '0;
    if (ri_q)
      mem_address = addr_q;
    else if (reading)
      mem_address = rptr[ADDR_W-1:0];
  end

endmodule
